// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 VGA timing constants and the stage-1 decode bundle.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: H_*/V_* timing values, totals, sync window bounds, decode_t struct.
package vga_timing_pkg;

    // Horizontal timing in pixel clocks.
    localparam logic [15:0] H_VISIBLE = 16'd640;
    localparam logic [15:0] H_FRONT   = 16'd16;
    localparam logic [15:0] H_SYNC    = 16'd96;
    localparam logic [15:0] H_BACK    = 16'd48;
    localparam logic [15:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing in lines.
    localparam logic [15:0] V_VISIBLE = 16'd480;
    localparam logic [15:0] V_FRONT   = 16'd10;
    localparam logic [15:0] V_SYNC    = 16'd2;
    localparam logic [15:0] V_BACK    = 16'd33;
    localparam logic [15:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: [START, END).
    localparam logic [15:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [15:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [15:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [15:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // 640x480 uses active-low syncs.
    localparam logic SYNC_POL_DEFAULT = 1'b0;

    // Stage-1 decode results carried into the output stage.
    typedef struct packed {
        logic       h_vis;
        logic       v_vis;
        logic       hs_act;
        logic       vs_act;
        logic       ls;
        logic       fs;
        logic       err;
        logic [9:0] h;
        logic [9:0] v;
    } decode_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Purpose: turns raw h/v counter values into registered VGA syncs, display enable, pixel coords and strobes.
// Latency: fixed 2 clk_25Mhz cycles from input counts to every output.
// Backpressure: none; free-running pipeline with no stalls or handshake.
// Ports: clk_25Mhz, d_reset (sync, active-high), h_count_value/v_count_value [15:0] in;
//        hsync, vsync, video_on, pixel_x/pixel_y [9:0], line_start, frame_start, count_err out;
//        frame_count [7:0] out only when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter logic SYNC_POL = SYNC_POL_DEFAULT
) (
    input  logic        clk_25Mhz,
    input  logic        d_reset,
    input  logic [15:0] h_count_value,
    input  logic [15:0] v_count_value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic        count_err
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_count
`endif
);

    decode_t dec;
    decode_t s1;
    logic    in_range;

    // Stage 1 decode. All compares use the full 16-bit counts so an
    // out-of-range value can never alias into a valid region via [9:0].
    always_comb begin
        dec      = '0;
        in_range = (h_count_value < H_TOTAL) && (v_count_value < V_TOTAL);
        dec.h_vis  = h_count_value < H_VISIBLE;
        dec.v_vis  = v_count_value < V_VISIBLE;
        // Gate the sync windows so an out-of-range count leaves syncs inactive.
        dec.hs_act = in_range && (h_count_value >= H_SYNC_START) && (h_count_value < H_SYNC_END);
        dec.vs_act = in_range && (v_count_value >= V_SYNC_START) && (v_count_value < V_SYNC_END);
        dec.ls     = (h_count_value == 16'd0);
        dec.fs     = (h_count_value == 16'd0) && (v_count_value == 16'd0);
        dec.err    = !in_range;
        dec.h      = h_count_value[9:0];
        dec.v      = v_count_value[9:0];
    end

    always_ff @(posedge clk_25Mhz) begin
        if (d_reset) begin
            s1 <= '0;
        end else begin
            s1 <= dec;
        end
    end

    // Stage 2: registered outputs. h_vis/v_vis are only true for in-range
    // counts, so video_on and the pixel coords are already zero otherwise.
    always_ff @(posedge clk_25Mhz) begin
        if (d_reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            count_err   <= 1'b0;
        end else begin
            hsync       <= s1.hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= s1.vs_act ? SYNC_POL : ~SYNC_POL;
            video_on    <= s1.h_vis & s1.v_vis;
            pixel_x     <= (s1.h_vis & s1.v_vis) ? s1.h : '0;
            pixel_y     <= (s1.h_vis & s1.v_vis) ? s1.v : '0;
            line_start  <= s1.ls;
            frame_start <= s1.fs;
            count_err   <= count_err | s1.err;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Counts on the same edge that raises frame_start; wraps naturally at 8 bits.
    always_ff @(posedge clk_25Mhz) begin
        if (d_reset) begin
            frame_count <= 8'd0;
        end else if (s1.fs) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: randomized and directed scoreboard bench for vga_sync_gen.
// Latency: expects every output 2 cycles after its input counts.
// Backpressure: none; one expected result per input cycle.
module tb_vga_sync_gen;

    logic        clk_25Mhz;
    logic        d_reset;
    logic [15:0] h_count_value;
    logic [15:0] v_count_value;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        line_start;
    logic        frame_start;
    logic        count_err;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]  frame_count;
`endif

    vga_sync_gen dut (
        .clk_25Mhz    (clk_25Mhz),
        .d_reset      (d_reset),
        .h_count_value(h_count_value),
        .v_count_value(v_count_value),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .count_err    (count_err)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count  (frame_count)
`endif
    );

    initial clk_25Mhz = 1'b0;
    always #20 clk_25Mhz = ~clk_25Mhz;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic       err;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        obs_t o;
        int   due;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model state: sticky error and frame counter.
    bit       err_m = 1'b0;
    bit [7:0] fc_m  = 8'd0;

    // Previous stimulus, finalized once the following cycle's reset is known.
    int prev_h, prev_v;
    bit prev_r;
    bit have_prev = 1'b0;

    always @(posedge clk_25Mhz) cyc <= cyc + 1;

    // Output for counts (h,v) per the 640x480 timing rules; rst_any means a
    // reset hit either pipeline stage while those counts were in flight.
    function automatic obs_t model(input int h, input int v, input bit rst_any);
        obs_t o;
        bit   oor, vis;
        o = '0;
        if (rst_any) begin
            err_m = 1'b0;
            fc_m  = 8'd0;
            o.hs  = 1'b1;
            o.vs  = 1'b1;
        end else begin
            oor   = (h >= 800) || (v >= 525);
            vis   = (h < 640) && (v < 480);
            o.hs  = !(!oor && h >= 656 && h < 752);
            o.vs  = !(!oor && v >= 490 && v < 492);
            o.von = vis;
            o.px  = vis ? 10'(h) : 10'd0;
            o.py  = vis ? 10'(v) : 10'd0;
            o.ls  = (h == 0);
            o.fs  = (h == 0) && (v == 0);
            err_m = err_m | oor;
            if (o.fs) fc_m = fc_m + 8'd1;
            o.err = err_m;
        end
`ifdef VGA_FRAME_CNT_EN
        o.fc = fc_m;
`else
        o.fc = 8'd0;
`endif
        return o;
    endfunction

    task automatic step(input int h, input int v, input bit r);
        ent_t e;
        @(negedge clk_25Mhz);
        h_count_value = h[15:0];
        v_count_value = v[15:0];
        d_reset       = r;
        if (have_prev) begin
            e.o   = model(prev_h, prev_v, prev_r | r);
            e.due = cyc + 1;
            q.push_back(e);
        end
        prev_h    = h;
        prev_v    = v;
        prev_r    = r;
        have_prev = 1'b1;
    endtask

    // Monitor: compares the DUT against the queue head when its due cycle arrives.
    initial begin
        obs_t act;
        forever begin
            @(posedge clk_25Mhz);
            #2;
            while (q.size() > 0 && q[0].due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stale_entry due=%0d now=%0d", q[0].due, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                act = '0;
                act.hs  = hsync;
                act.vs  = vsync;
                act.von = video_on;
                act.px  = pixel_x;
                act.py  = pixel_y;
                act.ls  = line_start;
                act.fs  = frame_start;
                act.err = count_err;
`ifdef VGA_FRAME_CNT_EN
                act.fc  = frame_count;
`endif
                n_cmp++;
                if (act !== q[0].o) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got hs=%b vs=%b von=%b px=%0d py=%0d ls=%b fs=%b err=%b fc=%0d want hs=%b vs=%b von=%b px=%0d py=%0d ls=%b fs=%b err=%b fc=%0d",
                             cyc, act.hs, act.vs, act.von, act.px, act.py, act.ls, act.fs, act.err, act.fc,
                             q[0].o.hs, q[0].o.vs, q[0].o.von, q[0].o.px, q[0].o.py,
                             q[0].o.ls, q[0].o.fs, q[0].o.err, q[0].o.fc);
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int vlist[9] = '{0, 1, 479, 480, 489, 490, 491, 492, 524};
        int hb[8]    = '{0, 639, 640, 655, 656, 751, 752, 799};
        int vb[8]    = '{0, 479, 480, 489, 490, 491, 492, 524};
        int h, v, wait_cyc;
        bit r;

        d_reset       = 1'b1;
        h_count_value = 16'd0;
        v_count_value = 16'd0;

        // Reset held for three cycles, then reset values stay visible.
        for (int i = 0; i < 3; i++) step(0, 0, 1'b1);

        // Full line sweeps on rows around the visible/sync boundaries.
        foreach (vlist[j]) begin
            for (int i = 0; i < 800; i++) step(i, vlist[j], 1'b0);
        end

        // Out-of-range count sets count_err and it sticks until reset.
        step(800, 0, 1'b0);
        for (int i = 1; i < 20; i++) step(i, 0, 1'b0);
        step(700, 600, 1'b0);
        step(100, 100, 1'b0);
        step(0, 0, 1'b1);
        for (int i = 0; i < 10; i++) step(i, 0, 1'b0);

        // Reset mid-frame at h=320, v=240, then resume.
        for (int i = 300; i < 320; i++) step(i, 240, 1'b0);
        step(320, 240, 1'b1);
        for (int i = 321; i < 341; i++) step(i, 240, 1'b0);

        // 257 frame starts: counter wraps past 255.
        for (int i = 0; i < 257; i++) begin
            step(0, 0, 1'b0);
            step(1, 0, 1'b0);
        end
        for (int i = 2; i < 6; i++) step(i, 0, 1'b0);

        // Randomized counts, mostly in range, with boundary picks and rare resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       h = $urandom_range(800, 65535);
                1, 2:    h = hb[$urandom_range(0, 7)];
                default: h = $urandom_range(0, 799);
            endcase
            case ($urandom_range(0, 9))
                0:       v = $urandom_range(525, 65535);
                1, 2:    v = vb[$urandom_range(0, 7)];
                default: v = $urandom_range(0, 524);
            endcase
            r = ($urandom_range(0, 199) == 0);
            step(h, v, r);
        end

        // Flush the pipeline and drain the scoreboard with a bounded wait.
        step(5, 5, 1'b0);
        step(6, 5, 1'b0);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk_25Mhz);
            wait_cyc++;
        end
        #5;
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain left=%0d want=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
